// File: rtl/drop_pkg.sv
// rtl/drop_pkg.sv - shared state encoding and Q8.8 constants for the drop sequencer
package drop_pkg;

  localparam int Q_W        = 16;
  localparam int HALF_SHIFT = 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DROP  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/drop_sequencer_tick_prescaler.sv
// rtl/drop_sequencer_tick_prescaler.sv - divides the clock into 1/256 time-unit ticks
module tick_prescaler #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] cnt_q;
  logic [PW-1:0] cnt_d;

  // tick is seen at the same edge the counter wraps, so the owner acts on it there
  assign tick = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == LAST) cnt_d = '0;
      else               cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/drop_sequencer.sv
// rtl/drop_sequencer.sv - halves the sqrt fall time, counts it down, then pulses drop and done
module drop_sequencer
  import drop_pkg::*;
#(
  parameter int TICK_DIV  = 4,
  parameter int DROP_HOLD = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           abort,
  input  logic [Q_W-1:0] t_sqrt,
  output logic           busy,
  output logic           drop,
  output logic           done,
  output logic [Q_W-1:0] remaining
);

  localparam int HW = (DROP_HOLD > 1) ? $clog2(DROP_HOLD) : 1;
  localparam logic [HW-1:0] LAST_HOLD = HW'(DROP_HOLD - 1);

  state_e         state_q, state_d;
  logic           busy_q, busy_d;
  logic           drop_q, drop_d;
  logic           done_q, done_d;
  logic [Q_W-1:0] remaining_q, remaining_d;
  logic [HW-1:0]  hold_q, hold_d;

  logic           accept;
  logic           tick;
  logic [Q_W-1:0] half_t;

  assign half_t = t_sqrt >> HALF_SHIFT;
  assign accept = (state_q == S_IDLE) && start && !abort;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state_q == S_COUNT),
    .clr   (accept || abort),
    .tick  (tick)
  );

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    drop_d      = drop_q;
    done_d      = done_q;
    remaining_d = remaining_q;
    hold_d      = hold_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          remaining_d = half_t;
          busy_d      = 1'b1;
          hold_d      = '0;
          // a zero fall time goes straight to the drop pulse
          if (half_t != '0) begin
            state_d = S_COUNT;
          end else begin
            state_d = S_DROP;
            drop_d  = 1'b1;
          end
        end
      end
      S_COUNT: begin
        if (abort) begin
          state_d     = S_IDLE;
          busy_d      = 1'b0;
          drop_d      = 1'b0;
          remaining_d = '0;
        end else if (tick && (remaining_q != '0)) begin
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == Q_W'(1)) begin
            state_d = S_DROP;
            drop_d  = 1'b1;
            hold_d  = '0;
          end
        end
      end
      S_DROP: begin
        if (abort) begin
          state_d     = S_IDLE;
          busy_d      = 1'b0;
          drop_d      = 1'b0;
          remaining_d = '0;
        end else if (hold_q == LAST_HOLD) begin
          state_d = S_DONE;
          drop_d  = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        done_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      drop_q      <= 1'b0;
      done_q      <= 1'b0;
      remaining_q <= '0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      drop_q      <= drop_d;
      done_q      <= done_d;
      remaining_q <= remaining_d;
      hold_q      <= hold_d;
    end
  end

  assign busy      = busy_q;
  assign drop      = drop_q;
  assign done      = done_q;
  assign remaining = remaining_q;

endmodule

// File: tb/tb_drop_sequencer.sv
// tb/tb_drop_sequencer.sv - scoreboard bench for the drop sequencer
module tb_drop_sequencer;

  localparam int TD   = 4;
  localparam int HOLD = 3;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] t_sqrt;
  logic        busy;
  logic        drop;
  logic        done;
  logic [15:0] remaining;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        busy;
    logic        drop;
    logic        done;
    logic [15:0] rem;
  } exp_t;

  exp_t sb_q[$];

  drop_sequencer #(
    .TICK_DIV  (TD),
    .DROP_HOLD (HOLD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .t_sqrt    (t_sqrt),
    .busy      (busy),
    .drop      (drop),
    .done      (done),
    .remaining (remaining)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t idle_exp();
    exp_t e;
    e.busy = 1'b0;
    e.drop = 1'b0;
    e.done = 1'b0;
    e.rem  = 16'd0;
    return e;
  endfunction

  // expected outputs k cycles after the start edge, from the published timing
  function automatic exp_t timing_exp(input int r, input int k);
    exp_t e;
    int d;
    e = idle_exp();
    d = r * TD;
    if (k < d) begin
      e.busy = 1'b1;
      e.rem  = 16'(r - k / TD);
    end else if (k < d + HOLD) begin
      e.busy = 1'b1;
      e.drop = 1'b1;
    end else if (k == d + HOLD) begin
      e.done = 1'b1;
    end
    return e;
  endfunction

  task automatic edge_and_compare(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check({tag, ".busy"}, 32'(busy), 32'(e.busy));
    check({tag, ".drop"}, 32'(drop), 32'(e.drop));
    check({tag, ".done"}, 32'(done), 32'(e.done));
    check({tag, ".remaining"}, 32'(remaining), 32'(e.rem));
  endtask

  // start at edge k=0; optional abort/reset/extra-start edges (-1 = none)
  task automatic run_case(input string name, input logic [15:0] ts, input int ncyc,
                          input int abort_k, input int rst_k, input int restart_k,
                          input logic [15:0] ts_late);
    int r;
    int cut;
    r   = int'(ts) / 2;
    cut = abort_k;
    if (rst_k >= 0 && (cut < 0 || rst_k < cut)) cut = rst_k;
    for (int k = 0; k < ncyc; k++) begin
      if (cut >= 0 && k >= cut) sb_q.push_back(idle_exp());
      else                      sb_q.push_back(timing_exp(r, k));
    end
    for (int k = 0; k < ncyc; k++) begin
      start  = (k == 0) || (k == restart_k);
      t_sqrt = (k == 0) ? ts : ts_late;
      abort  = (k == abort_k);
      rst_n  = (k != rst_k);
      edge_and_compare($sformatf("%s[%0d]", name, k));
    end
    start = 1'b0;
    abort = 1'b0;
    rst_n = 1'b1;
    sb_q.push_back(idle_exp());
    edge_and_compare({name, ".after"});
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b1;
    abort  = 1'b0;
    t_sqrt = 16'h000A;
    for (int i = 0; i < 2; i++) begin
      sb_q.push_back(idle_exp());
      edge_and_compare($sformatf("reset[%0d]", i));
    end
    rst_n = 1'b1;
    start = 1'b0;
    sb_q.push_back(idle_exp());
    edge_and_compare("reset.release");

    run_case("nominal",     16'h000A, 26, -1, -1, -1, 16'h1234);
    run_case("zero_r",      16'h0001,  7, -1, -1,  4, 16'h0001);
    run_case("abort_cnt",   16'h0010, 40, 10, -1, -1, 16'h0010);
    run_case("restart_ign", 16'h0006, 18, -1, -1,  5, 16'hFFFF);
    run_case("max_r",       16'hFFFF, 12,  9, -1, -1, 16'hFFFF);
    run_case("rst_drop",    16'h0004, 14, -1,  9, -1, 16'h0004);
    run_case("abort_start", 16'h000A,  3,  0, -1, -1, 16'h000A);
    run_case("abort_drop",  16'h0002, 10,  5, -1, -1, 16'h0002);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/drop_sequencer.md
Name: drop_sequencer

Overview:
- Sequential stage directly downstream of the square-root unit in the baggage-drop datapath.
- Takes the Q8.8 square-root result and halves it to get the actual fall time t_act = sqrt/2.
- Counts that time down in 1/256 time-unit ticks, then pulses the drop command for a fixed number of cycles and reports completion.
- Sits between the square-root unit and the drop actuator/display logic.

Parameters:
- TICK_DIV, 4, clock cycles per 1/256 time unit (LSB of Q8.8). Must be at least 1.
- DROP_HOLD, 3, number of cycles the drop output stays high. Must be at least 1.

Ports:
- clk  in  1  system clock; all logic updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  request to begin a drop sequence; sampled only in IDLE.
- abort  in  1  cancel the current sequence.
- t_sqrt  in  16  Q8.8 square-root result from the upstream square-root unit.
- busy  out  1  high while in COUNT or DROP.
- drop  out  1  drop command to the actuator.
- done  out  1  one-cycle completion pulse.
- remaining  out  16  current countdown value in 1/256 time units.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset: when rst_n=0 at a rising edge:
  - state goes to IDLE.
  - busy, drop, done and remaining go to 0.
  - prescaler and hold counter go to 0.
  - Reset has priority over everything, including mid-COUNT and mid-DROP (drop falls at that edge).
- All outputs are registered (Moore style).
- States: IDLE, COUNT, DROP, DONE.
- IDLE, start=1, abort=0 at edge E0:
  - remaining <= t_sqrt >> 1 (truncating). Call this value R.
  - prescaler <= 0.
  - If R != 0: state <= COUNT, busy <= 1.
  - If R == 0: state <= DROP, busy <= 1, drop <= 1.
- COUNT:
  - prescaler increments each cycle.
  - When prescaler == TICK_DIV-1: prescaler <= 0 and remaining <= remaining-1.
  - If that decrement takes remaining from 1 to 0: state <= DROP, drop <= 1, hold counter <= 0 at the same edge.
  - Timing: decrements occur at E0+TICK_DIV, E0+2*TICK_DIV, and so on. drop rises at E0+R*TICK_DIV.
- DROP:
  - Hold counter increments each cycle; drop stays high for exactly DROP_HOLD cycles.
  - At the edge where the hold counter reaches DROP_HOLD-1: drop <= 0, busy <= 0, done <= 1, state <= DONE.
- DONE:
  - done is high for exactly one cycle.
  - Next edge: done <= 0, state <= IDLE.
  - start is not accepted in DONE.
- start while not in IDLE: ignored, no restart.
- abort:
  - Priority over start.
  - In COUNT or DROP: state <= IDLE, busy/drop/remaining <= 0, prescaler <= 0; no done pulse.
  - In IDLE or DONE: ignored, except that it suppresses a simultaneous start.
- Width rules:
  - R is at most 0x7FFF, so there is no overflow.
  - remaining never wraps below 0.
  - Prescaler width is clog2(TICK_DIV), minimum 1 bit.
  - Hold counter width is clog2(DROP_HOLD), minimum 1 bit.
- t_sqrt is sampled only at the start edge; later changes have no effect.

Decomposition:
- Shared package drop_pkg holds:
  - the state encoding (IDLE=0, COUNT=1, DROP=2, DONE=3);
  - the Q8.8 width constant (16);
  - the halving shift constant (1).
- One natural sub-module: tick_prescaler (enable, clear, TICK_DIV parameter). It emits a one-cycle tick on the TICK_DIV-th enabled cycle and is instantiated for COUNT.
- FSM, hold counter and output registers stay in drop_sequencer.

Test Plan:
- rst_n=0 for 2 cycles with start=1 -> busy=drop=done=0 and remaining=0 throughout; no sequence starts.
- Defaults, t_sqrt=0x000A, start pulse at E0:
  - remaining=5 after E0, busy=1.
  - remaining=4 at E0+4, continuing down to 0 at E0+20.
  - drop=1 during E0+20..E0+22, done=1 for exactly one cycle after E0+23, busy=0 from E0+23.
- t_sqrt=0x0001 (R=0), start at E0 -> drop=1 immediately after E0 for 3 cycles, then one done pulse; remaining stays 0.
- t_sqrt=0x0010 (R=8), abort at E0+10 -> after that edge busy=0, remaining=0; drop and done never assert.
- During COUNT, start=1 with t_sqrt=0xFFFF -> ignored; original countdown continues unchanged.
- t_sqrt=0xFFFF -> remaining=0x7FFF after start.
- rst_n=0 mid-DROP -> drop=0 after that edge, state IDLE, no done pulse.
